// File: rtl/d_ram_dma_pkg.sv
// d_ram_dma_pkg: shared state encoding for the data-RAM block-move engine
package d_ram_dma_pkg;
  typedef enum logic [1:0] {IDLE, COPY, FILL, DRAIN} state_t;
endpackage

// File: rtl/d_ram_dma_addr_seq.sv
// d_ram_dma_addr_seq: latched base plus offset counter producing a wrapped RAM address
module d_ram_dma_addr_seq #(
  parameter int addr_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] base,
  output logic [addr_width-1:0] off,
  output logic [addr_width-1:0] addr
);
  logic [addr_width-1:0] base_q;
  // load captures a new base and restarts the offset; step advances one byte
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      off    <= '0;
    end else if (load) begin
      base_q <= base;
      off    <= '0;
    end else if (step) begin
      off <= off + 1'b1;
    end
  end
  assign addr = base_q + off;
endmodule

// File: rtl/d_ram_dma.sv
// d_ram_dma: single-channel copy/fill engine driving both data-RAM ports
module d_ram_dma
  import d_ram_dma_pkg::*;
#(
  parameter int addr_width = 12,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [addr_width-1:0] src,
  input  logic [addr_width-1:0] dst,
  input  logic [addr_width:0]   len,
  input  logic [data_width-1:0] fill_val,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_r_addr,
  output logic                  ram_r_en,
  input  logic [data_width-1:0] ram_rdata,
  output logic [addr_width-1:0] ram_w_addr,
  output logic                  ram_w_en,
  output logic [data_width-1:0] ram_din
);
  state_t state, nxt;
  logic [addr_width-1:0] len_m1, rd_off, rd_addr, wr_off, wr_addr;
  logic [data_width-1:0] fill_q;
  logic accept, wr_pend, rd_last, wr_last;
  assign accept  = state == IDLE && start;
  assign rd_last = rd_off == len_m1;
  assign wr_last = wr_off == len_m1;
  d_ram_dma_addr_seq #(.addr_width(addr_width)) u_rd (
    .clk(clk), .rst(rst), .load(accept), .step(ram_r_en), .base(src), .off(rd_off), .addr(rd_addr)
  );
  d_ram_dma_addr_seq #(.addr_width(addr_width)) u_wr (
    .clk(clk), .rst(rst), .load(accept), .step(ram_w_en), .base(dst), .off(wr_off), .addr(wr_addr)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state; a zero-length request never leaves IDLE
  always_comb begin
    nxt = state == IDLE  ? (accept && len != '0 ? (mode ? FILL : COPY) : IDLE) :
          state == COPY  ? (rd_last ? DRAIN : COPY) :
          state == DRAIN ? IDLE :
                           (wr_last ? IDLE : FILL);
  end
  // operand latches, copy write lag and the registered completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      len_m1  <= '0;
      fill_q  <= '0;
      wr_pend <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        len_m1 <= addr_width'(len - 1'b1);
        fill_q <= fill_val;
      end
      wr_pend <= state == COPY;
      done    <= (accept && len == '0) || state == DRAIN || (state == FILL && wr_last);
    end
  end
  // RAM port drive; addresses and data are held at zero whenever the port is idle
  always_comb begin
    busy       = state != IDLE;
    ram_r_en   = state == COPY;
    ram_w_en   = state == FILL || wr_pend;
    ram_r_addr = ram_r_en ? rd_addr : '0;
    ram_w_addr = ram_w_en ? wr_addr : '0;
    ram_din    = state == FILL ? fill_q : wr_pend ? ram_rdata : '0;
  end
endmodule

// File: tb/tb_d_ram_dma.sv
// tb_d_ram_dma: directed checks of d_ram_dma against a behavioural data RAM
module tb_d_ram_dma;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [11:0] src = 0, dst = 0;
  logic [12:0] len = 0;
  logic [7:0] fill_val = 0;
  logic busy, done, ram_r_en, ram_w_en;
  logic [11:0] ram_r_addr, ram_w_addr;
  logic [7:0] ram_rdata, ram_din;
  logic [7:0] mem [4096];
  logic bk_we = 0;
  logic [11:0] bk_a = 0;
  logic [7:0] bk_d = 0;
  int checks = 0, errors = 0;
  int rcnt, wcnt, bcnt, dcyc, rfirst, wfirst, ridx, busy_at_done;
  logic [11:0] radr [8];

  d_ram_dma dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst), .len(len),
    .fill_val(fill_val), .busy(busy), .done(done), .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en),
    .ram_rdata(ram_rdata), .ram_w_addr(ram_w_addr), .ram_w_en(ram_w_en), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // data RAM with registered read; bench preload port used only while idle
  always @(posedge clk) begin
    if (ram_r_en) ram_rdata <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_din;
    else if (bk_we) mem[bk_a] <= bk_d;
  end

  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task poke(input logic [11:0] a, input logic [7:0] d);
    bk_a = a; bk_d = d; bk_we = 1;
    @(posedge clk); #1 bk_we = 0;
  endtask

  task check_idle_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".r_en"}, ram_r_en, 0);
    check({tag, ".w_en"}, ram_w_en, 0);
    check({tag, ".r_addr"}, ram_r_addr, 0);
    check({tag, ".w_addr"}, ram_w_addr, 0);
    check({tag, ".din"}, ram_din, 0);
  endtask

  // inj: 0 none, 1 stray start in cycle T+2, 2 reset asserted in cycle T+3
  task run(input logic m, input logic [11:0] s, input logic [11:0] d, input logic [12:0] l,
           input logic [7:0] f, input int inj);
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1;
    @(posedge clk);
    #1 start = 0; src = 12'hABC; dst = 12'hABC; len = 13'd9; fill_val = 8'h99; mode = ~m;
    rcnt = 0; wcnt = 0; bcnt = 0; dcyc = 0; rfirst = 0; wfirst = 0; ridx = 0; busy_at_done = 0;
    for (int n = 1; n <= 30 && dcyc == 0; n++) begin
      @(negedge clk);
      if (inj == 2 && n == 4) begin
        check_idle_zero("rst_mid");
        rst = 0;
      end
      rcnt += int'(ram_r_en);
      wcnt += int'(ram_w_en);
      bcnt += int'(busy);
      if (ram_r_en && rfirst == 0) rfirst = n;
      if (ram_w_en && wfirst == 0) wfirst = n;
      if (ram_r_en && ridx < 8) begin
        radr[ridx] = ram_r_addr;
        ridx++;
      end
      if (done) begin
        dcyc = n;
        busy_at_done = int'(busy);
      end
      if (inj == 1 && n == 2) begin
        start = 1; mode = 1; dst = 12'h300; len = 13'd2; fill_val = 8'hEE;
      end
      if (inj == 1 && n == 3) start = 0;
      if (inj == 2 && n == 3) rst = 1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 0;
    poke(12'h010, 8'h11); poke(12'h011, 8'h22); poke(12'h012, 8'h33); poke(12'h013, 8'h44);
    poke(12'h014, 8'h55); poke(12'h015, 8'h66); poke(12'h016, 8'h77); poke(12'h017, 8'h88);
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hB2); poke(12'h000, 8'hC3); poke(12'h001, 8'hD4);
    poke(12'h203, 8'h77); poke(12'h300, 8'h33);
    poke(12'h600, 8'h00); poke(12'h601, 8'h00); poke(12'h602, 8'h00); poke(12'h603, 8'h00);

    run(0, 12'h010, 12'h100, 13'd4, 8'h00, 0);
    check("copy.rcnt", rcnt, 4);
    check("copy.wcnt", wcnt, 4);
    check("copy.rfirst", rfirst, 1);
    check("copy.wfirst", wfirst, 2);
    check("copy.busy", bcnt, 5);
    check("copy.done", dcyc, 6);
    check("copy.busy_at_done", busy_at_done, 0);
    check("copy.m100", mem[12'h100], 8'h11);
    check("copy.m101", mem[12'h101], 8'h22);
    check("copy.m102", mem[12'h102], 8'h33);
    check("copy.m103", mem[12'h103], 8'h44);

    run(1, 12'h000, 12'h200, 13'd3, 8'hA5, 0);
    check("fill.rcnt", rcnt, 0);
    check("fill.wcnt", wcnt, 3);
    check("fill.busy", bcnt, 3);
    check("fill.done", dcyc, 4);
    check("fill.m200", mem[12'h200], 8'hA5);
    check("fill.m201", mem[12'h201], 8'hA5);
    check("fill.m202", mem[12'h202], 8'hA5);
    check("fill.m203", mem[12'h203], 8'h77);

    run(0, 12'hFFE, 12'h020, 13'd4, 8'h00, 0);
    check("wrap.rcnt", rcnt, 4);
    check("wrap.ra0", radr[0], 12'hFFE);
    check("wrap.ra1", radr[1], 12'hFFF);
    check("wrap.ra2", radr[2], 12'h000);
    check("wrap.ra3", radr[3], 12'h001);
    check("wrap.done", dcyc, 6);
    check("wrap.m020", mem[12'h020], 8'hA1);
    check("wrap.m021", mem[12'h021], 8'hB2);
    check("wrap.m022", mem[12'h022], 8'hC3);
    check("wrap.m023", mem[12'h023], 8'hD4);

    run(0, 12'h010, 12'h700, 13'd0, 8'h00, 0);
    check("zero.done", dcyc, 1);
    check("zero.busy", bcnt, 0);
    check("zero.rcnt", rcnt, 0);
    check("zero.wcnt", wcnt, 0);

    run(0, 12'h010, 12'h400, 13'd4, 8'h00, 1);
    check("bstart.done", dcyc, 6);
    check("bstart.wcnt", wcnt, 4);
    check("bstart.m300", mem[12'h300], 8'h33);
    check("bstart.m400", mem[12'h400], 8'h11);
    check("bstart.m403", mem[12'h403], 8'h44);

    run(1, 12'h000, 12'h500, 13'd2, 8'h5C, 0);
    check("b2b.done", dcyc, 3);
    check("b2b.m500", mem[12'h500], 8'h5C);
    check("b2b.m501", mem[12'h501], 8'h5C);

    run(0, 12'h010, 12'h600, 13'd8, 8'h00, 2);
    check("rst_mid.nodone", dcyc, 0);
    check("rst_mid.m600", mem[12'h600], 8'h11);
    check("rst_mid.m601", mem[12'h601], 8'h22);
    check("rst_mid.m602", mem[12'h602], 8'h00);
    check("rst_mid.m603", mem[12'h603], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
